instr_encoder: RTL
==================

# instr_encoder

Sequential instruction encoder and loader for the pipelined MIPS core. It is the inverse of the control/decode path: it accepts field-level instruction requests over a valid/ready handshake, packs them into 32-bit MIPS words, and writes them sequentially into instruction memory through a backpressured write port. Benches and the boot loader use it to build program images for the supported subset: R-format, lw, sw, beq, j, andi and nop.

## Interface
- ADDR_W, 10, word-address width of instruction memory.
- BASE_ADDR, 0, first word address written after reset or `start`. Must be below 2**ADDR_W.
- LIMIT (derived, not overridable) = 2**ADDR_W − BASE_ADDR, the number of writable words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  synchronous restart of the program image.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted on the cycle where in_valid && in_ready.
- in_op  in  3  0 NOP, 1 RTYPE, 2 LW, 3 SW, 4 BEQ, 5 J, 6 ANDI, 7 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  R-format function code.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target field.
- mem_we  out  1  write request; equal to out_valid.
- mem_addr  out  ADDR_W  word address of the pending word.
- mem_wdata  out  32  encoded word.
- mem_ready  in  1  memory accepts the write this cycle.
- word_count  out  ADDR_W+1  number of words written since reset or `start`.
- err_illegal  out  1  sticky flag; set when an illegal op is consumed.

## Operation
- **Encoding:**
  - NOP → 32'h0.
  - RTYPE → {6'd0, rs, rt, rd, shamt, funct}.
  - LW → {6'd35, rs, rt, imm}.
  - SW → {6'd43, rs, rt, imm}.
  - BEQ → {6'd4, rs, rt, imm}.
  - J → {6'd2, target}.
  - ANDI → {6'd12, rs, rt, imm}.
  - Fields not used by an op are ignored.
- **Output register:** one word deep, holding out_valid, mem_wdata and mem_addr.
  - A write completes when mem_we && mem_ready.
  - On completion, the address counter increments and word_count increments.
- **in_ready** = (!out_valid || mem_ready) && (word_count + out_valid < LIMIT) && !start.
- **Accepted legal op:** loads the output register. mem_addr = BASE_ADDR + word_count + (completing write ? 1 : 0), i.e. the next sequential address.
- **Accepted illegal op (7):** consumed with no word emitted. err_illegal is set, and out_valid clears if the held word completes this cycle.
- **Full:** when word_count + out_valid == LIMIT, in_ready stays low until `start` or reset. Addresses never wrap.
- **start (priority over everything except reset):**
  - Discards any pending word, so mem_we drops next cycle with no write counted.
  - word_count ← 0, next address ← BASE_ADDR, err_illegal ← 0.
  - in_ready is low during the `start` cycle.
- **Reset values (rst_n low at an edge):** out_valid/mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, word_count 0, err_illegal 0. in_ready evaluates to 1 after reset.
- **Reset mid-write:** a pending word is dropped and not counted.

## Timing
- Latency: a request accepted at edge k drives mem_we=1 with its word from edge k, visible in cycle k+1.
- Throughput: one word per cycle when mem_ready stays high.
  - Back-to-back accepts are allowed when the held word completes in the same cycle.
- Backpressure: while mem_ready=0 with a word pending, mem_wdata and mem_addr are held stable and in_ready=0.
- word_count updates at the edge ending the completing cycle.
- Inputs are sampled only on handshake cycles; the in_* fields are don't-care otherwise.
- in_ready is combinational from out_valid, mem_ready, start and word_count. No combinational path from in_valid to in_ready.

## Test plan
- **Encode all ops, mem_ready tied to 1, BASE_ADDR=0:**
  - LW rs=29 rt=8 imm=4 → 0x8FA80004 @0.
  - SW rs=29 rt=8 imm=8 → 0xAFA80008 @1.
  - RTYPE rs=9 rt=10 rd=8 funct=0x20 → 0x012A4020 @2.
  - BEQ rs=8 rt=9 imm=0xFFFF → 0x1109FFFF @3.
  - J target=0x10 → 0x08000010 @4.
  - ANDI rs=8 rt=9 imm=0xFF → 0x310900FF @5.
  - NOP → 0x00000000 @6.
  - Expect word_count=7.
- **Backpressure:** hold mem_ready=0 for 5 cycles with a word pending → mem_wdata and mem_addr stable, in_ready=0, word_count unchanged. Then release → one write, and in_ready=1 the same cycle.
- **Illegal op:** op=7 between two LWs → only 2 words written at consecutive addresses 0 and 1, err_illegal=1 and staying set until `start`.
- **Full with ADDR_W=2, BASE_ADDR=1:** stream 5 requests → exactly 3 writes at addresses 1, 2, 3. in_ready=0 after the third accept, word_count=3.
- **start mid-stream:** assert start while a word is pending with mem_ready=0 → no write, mem_we=0 next cycle, word_count=0. The next accepted word goes to BASE_ADDR and err_illegal is cleared.
- **Reset mid-operation:** drive rst_n=0 for 1 cycle with a word pending → all outputs return to reset values, in_ready=1 afterwards, and the first write after reset goes to BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request and memory-write bundle for instr_encoder: field-level instruction
// requests in, sequential instruction-memory writes and status out.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [ADDR_W:0]   word_count;
  logic              err_illegal;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
           in_target, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, word_count, err_illegal
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
           in_target, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, word_count, err_illegal
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs field-level MIPS instruction requests into 32-bit words and writes them
// sequentially into instruction memory through a one-deep output register.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  instr_encoder_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_RTYPE = 3'd1,
    OP_LW    = 3'd2,
    OP_SW    = 3'd3,
    OP_BEQ   = 3'd4,
    OP_J     = 3'd5,
    OP_ANDI  = 3'd6,
    OP_ILL   = 3'd7
  } op_e;

  localparam int unsigned     LIMIT_I = (1 << ADDR_W) - BASE_ADDR;
  localparam logic [ADDR_W:0] LIMIT   = LIMIT_I[ADDR_W:0];
  localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];

  function automatic logic [31:0] enc_word(
    input logic [2:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    case (op_e'(op))
      OP_RTYPE: w = {6'd0, rs, rt, rd, shamt, funct};
      OP_LW:    w = {6'd35, rs, rt, imm};
      OP_SW:    w = {6'd43, rs, rt, imm};
      OP_BEQ:   w = {6'd4, rs, rt, imm};
      OP_J:     w = {6'd2, target};
      OP_ANDI:  w = {6'd12, rs, rt, imm};
      default:  w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  logic              complete_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              legal_s;
  logic [ADDR_W:0]   occupancy_s;
  logic [ADDR_W-1:0] next_addr_s;

  // Handshake qualifiers; in_ready never looks at in_valid.
  always_comb begin
    complete_s  = out_valid_q && bus.mem_ready;
    occupancy_s = count_q + {{ADDR_W{1'b0}}, out_valid_q};
    in_ready_s  = (!out_valid_q || bus.mem_ready) && (occupancy_s < LIMIT) && !start;
    accept_s    = bus.in_valid && in_ready_s;
    legal_s     = (bus.in_op != OP_ILL);
    // count_q < LIMIT whenever a word can be accepted, so this never wraps
    next_addr_s = BASE + count_q[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, complete_s};
  end

  // Next-state for the output register, write counter and sticky error.
  always_comb begin
    out_valid_d = out_valid_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    if (start) begin
      out_valid_d = 1'b0;
      addr_d      = BASE;
      count_d     = {(ADDR_W+1){1'b0}};
      err_d       = 1'b0;
    end else begin
      if (complete_s) begin
        count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
        count_d = count_q;
      end
      if (accept_s && legal_s) begin
        out_valid_d = 1'b1;
        wdata_d     = enc_word(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd,
                               bus.in_shamt, bus.in_funct, bus.in_imm, bus.in_target);
        addr_d      = next_addr_s;
      end else if (accept_s) begin
        err_d       = 1'b1;
        out_valid_d = out_valid_q && !complete_s;
      end else if (complete_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      addr_q      <= BASE;
      count_q     <= {(ADDR_W+1){1'b0}};
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.mem_we      = out_valid_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.word_count  = count_q;
  assign bus.err_illegal = err_q;

endmodule
